// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StResp  = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane logic: extracts/extends a loaded byte or half from a word, and merges a
// sub-word store value into an existing word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_extract,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lane;
  logic [31:0] w_mask;

  always_comb begin
    // Offset 0 is the most significant byte.
    case (i_off)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[15:0] : i_word[31:16];

    case (i_size)
      SIZE_BYTE: o_extract = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_extract = {{16{~i_unsigned & w_half[15]}}, w_half};
      default:   o_extract = i_word;
    endcase
  end

  always_comb begin
    case (i_size)
      SIZE_BYTE: begin
        w_lane = {4{i_wdata[7:0]}};
        w_mask = 32'hFF00_0000 >> {i_off, 3'b000};
      end
      SIZE_HALF: begin
        w_lane = {2{i_wdata[15:0]}};
        w_mask = i_off[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      end
      default: begin
        w_lane = i_wdata;
        w_mask = 32'hFFFF_FFFF;
      end
    endcase
    o_merge = (i_word & ~w_mask) | (w_lane & w_mask);
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns byte/half/word requests into aligned word accesses to a
// word-wide big-endian datamem, with read-modify-write for sub-word stores.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_req,
  output logic        mem_ready,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_err,
  output logic [31:0] data_addr,
  output logic        data_wr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in
);

  lsu_state_e  r_state, w_state_nxt;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_wdata, r_word, r_data_addr, r_data_out;

  logic        w_accept, w_err_in;
  logic [2:0]  w_bytes;
  logic [32:0] w_end;
  logic [31:0] w_extract, w_merge, w_wr_val;

  assign w_accept = (r_state == StIdle) & mem_req;

  always_comb begin
    case (mem_size)
      SIZE_BYTE: w_bytes = 3'd1;
      SIZE_HALF: w_bytes = 3'd2;
      default:   w_bytes = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    w_end    = {1'b0, mem_addr} + {30'd0, w_bytes};
    w_err_in = (mem_size == SIZE_RSVD)
             | ((mem_size == SIZE_HALF) & mem_addr[0])
             | ((mem_size == SIZE_WORD) & (mem_addr[1:0] != 2'b00))
             | (w_end > 33'(MEM_BYTES));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: begin
        if (mem_req) begin
          if (w_err_in)                             w_state_nxt = StResp;
          else if (mem_we && mem_size == SIZE_WORD) w_state_nxt = StWrite;
          else                                      w_state_nxt = StRead;
        end
      end
      StRead:  w_state_nxt = r_we ? StWrite : StResp;
      StWrite: w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  lsu_align u_align (
    .i_word     (r_word),
    .i_wdata    (r_wdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_extract  (w_extract),
    .o_merge    (w_merge)
  );

  always_comb begin
    w_wr_val  = (r_size == SIZE_WORD) ? r_wdata : w_merge;
    mem_ready = (r_state == StIdle);
    mem_done  = (r_state == StResp);
    mem_err   = mem_done & r_err;
    mem_rdata = (mem_done & ~r_we & ~r_err) ? w_extract : 32'd0;
    data_addr = r_data_addr;
    // Gated with nrst so a reset edge landing in WRITE never commits a store.
    data_wr   = (r_state == StWrite) & nrst;
    data_out  = (r_state == StWrite) ? w_wr_val : r_data_out;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= StIdle;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_err       <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_wdata     <= 32'd0;
      r_word      <= 32'd0;
      r_data_addr <= 32'd0;
      r_data_out  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= mem_we;
        r_uns   <= mem_unsigned;
        r_err   <= w_err_in;
        r_size  <= mem_size;
        r_off   <= mem_addr[1:0];
        r_wdata <= mem_wdata;
      end
      // Errored requests leave the memory-side address untouched.
      if (w_accept && !w_err_in) r_data_addr <= {mem_addr[31:2], 2'b00};
      if (r_state == StRead)     r_word      <= data_in;
      if (r_state == StWrite)    r_data_out  <= w_wr_val;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu with a word-wide datamem; checks against a byte-array reference memory.
module tb_mem_lsu;

  localparam int MemBytes = 1024;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;
  logic [31:0] data_addr;
  logic        data_wr;
  logic [31:0] data_out;
  logic [31:0] data_in;

  logic [7:0]  ref_b [MemBytes];
  logic [31:0] dmem  [MemBytes/4];
  logic        init_go = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.MEM_BYTES(MemBytes)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .mem_err      (mem_err),
    .data_addr    (data_addr),
    .data_wr      (data_wr),
    .data_out     (data_out),
    .data_in      (data_in)
  );

  assign data_in = dmem[data_addr[9:2]];

  always @(posedge clk) begin
    if (init_go) begin
      for (int i = 0; i < MemBytes / 4; i++)
        dmem[i] <= {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]};
    end else if (data_wr) begin
      dmem[data_addr[9:2]] <= data_out;
    end
  end

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx], ref_b[4*idx+1], ref_b[4*idx+2], ref_b[4*idx+3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for mem_done, check timing/result/write count and the touched word.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    int          n, lat, wrs, exp_lat, exp_wrs;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [63:0] a64;
    n       = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a64     = {32'd0, addr};
    exp_err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)
              || (a64 + 64'(n) > 64'(MemBytes));
    exp_rd  = 32'd0;
    exp_wrs = 0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 32'(ref_b[int'(addr) + i]);
      if (!uns && n == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
      if (!uns && n == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
    end else begin
      exp_lat = (n == 4) ? 2 : 3;
      exp_wrs = 1;
      for (int i = 0; i < n; i++) ref_b[int'(addr) + i] = 8'(wd >> (8 * (n - 1 - i)));
    end

    @(negedge clk);
    check_eq("ready_before_req", 32'(mem_ready), 32'd1);
    mem_req = 1'b1; mem_we = we; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; mem_wdata = wd;
    @(negedge clk);
    lat = 1;
    wrs = 0;
    while (!mem_done && lat < 8) begin
      if (data_wr) wrs++;
      // Busy-state inputs must be ignored.
      mem_req = 1'($urandom); mem_we = 1'($urandom); mem_size = 2'($urandom);
      mem_unsigned = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
      @(negedge clk);
      lat++;
    end
    mem_req = 1'b0;
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("mem_err", 32'(mem_err), 32'(exp_err));
    check_eq("mem_rdata", mem_rdata, exp_rd);
    check_eq("write_pulses", 32'(wrs), 32'(exp_wrs));
    check_eq("mem_word", dmem[addr[9:2]], ref_word(int'(addr[9:2])));
    rd = mem_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int          cnt;

    for (int i = 0; i < MemBytes; i++) ref_b[i] = 8'($urandom);
    {ref_b[16], ref_b[17], ref_b[18], ref_b[19]} = 32'h1122_3344;
    {ref_b[32], ref_b[33], ref_b[34], ref_b[35]} = 32'h80FF_0000;

    init_go = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(mem_ready), 32'd1);
    check_eq("rst_done", 32'(mem_done), 32'd0);
    check_eq("rst_err", 32'(mem_err), 32'd0);
    check_eq("rst_rdata", mem_rdata, 32'd0);
    check_eq("rst_data_wr", 32'(data_wr), 32'd0);
    check_eq("rst_data_addr", data_addr, 32'd0);
    check_eq("rst_data_out", data_out, 32'd0);
    init_go = 1'b0;
    nrst = 1'b1;

    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, rd); check_eq("lb_11", rd, 32'h0000_0022);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd); check_eq("lbu_13", rd, 32'h0000_0044);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, rd); check_eq("lh_20", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, rd); check_eq("lhu_22", rd, 32'h0000_0000);
    do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'd0, rd); check_eq("lb_21", rd, 32'hFFFF_FFFF);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hAABB_CCDD, rd);
    check_eq("sb_12_word", dmem[4], 32'h1122_DD44);
    do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_BEEF, rd);
    check_eq("sh_10_word", dmem[4], 32'hBEEF_DD44);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, rd);
    check_eq("sw_10_word", dmem[4], 32'hCAFE_F00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, rd);
    do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h1234_5678, rd);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h1234_5678, rd);
    do_req(1'b0, 2'd2, 1'b0, 32'h3FE, 32'd0, rd);
    do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h5555_5555, rd);
    do_req(1'b0, 2'd0, 1'b1, 32'h3FF, 32'd0, rd);
    do_req(1'b1, 2'd1, 1'b0, 32'h3FE, 32'h0000_A5A5, rd);

    // Reset asserted while a byte store is in its WRITE cycle.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h24; mem_wdata = 32'h5A;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_wr_before", 32'(data_wr), 32'd1);
    nrst = 1'b0;
    #1;
    check_eq("rst_mid_wr_gated", 32'(data_wr), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_ready", 32'(mem_ready), 32'd1);
    check_eq("rst_mid_mem", dmem[9], ref_word(9));
    nrst = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_done) cnt++;
    end
    check_eq("rst_mid_no_done", 32'(cnt), 32'd0);

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(1016, 1031));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, MemBytes - 1));
      endcase
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd);
    end

    for (int i = 0; i < MemBytes / 4; i++) check_eq("final_mem", dmem[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
